// File: rtl/uart_tx_arb_pkg.sv
// Shared types and widths for the UART TX arbiter: FSM state encoding and
// statistics counter widths.
package uart_tx_arb_pkg;

   localparam int STATE_W     = 2;
   localparam int FRAME_CNT_W = 16;
   localparam int ERR_CNT_W   = 8;

   typedef enum logic [STATE_W-1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / UART-facing bundle of the arbiter. The frame_count/err_count
// outputs exist only when UART_TX_ARB_STATS_EN is defined.
interface uart_tx_arbiter_if
   import uart_tx_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            ack;
   logic                          tx_start;
   logic [DATA_WIDTH-1:0]         tx_data;
   logic                          tx_busy;
   logic [IDX_W-1:0]              grant_id;
   logic                          done;
   logic                          err;
`ifdef UART_TX_ARB_STATS_EN
   logic [FRAME_CNT_W-1:0]        frame_count;
   logic [ERR_CNT_W-1:0]          err_count;

   modport master (
      input  req, req_data, tx_busy,
      output ack, tx_start, tx_data, grant_id, done, err, frame_count, err_count
   );
   modport slave (
      output req, req_data, tx_busy,
      input  ack, tx_start, tx_data, grant_id, done, err, frame_count, err_count
   );
`else
   modport master (
      input  req, req_data, tx_busy,
      output ack, tx_start, tx_data, grant_id, done, err
   );
   modport slave (
      output req, req_data, tx_busy,
      input  ack, tx_start, tx_data, grant_id, done, err
   );
`endif

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotating-priority selector: finds the first set request
// starting at last+1 and wrapping modulo NUM_REQ.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last,
   output logic               o_valid,
   output logic [IDX_W-1:0]   o_idx
);

   always_comb begin
      int w_cand;
      // NOTE: every output of a combinational block gets a default first, so no
      // path through the block can leave it unassigned and infer a latch.
      w_cand  = 0;
      o_valid = 1'b0;
      o_idx   = '0;
      // Scan from the farthest candidate to the nearest; the nearest hit wins.
      for (int off = NUM_REQ; off >= 1; off--) begin
         w_cand = int'(i_last) + off;
         if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
         if (i_req[w_cand]) begin
            o_valid = 1'b1;
            o_idx   = IDX_W'(w_cand);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ producers.
// Optional statistics counters are enabled with UART_TX_ARB_STATS_EN.
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int START_TIMEOUT = 4
) (
   input logic               clk,
   input logic               rst,
   uart_tx_arbiter_if.master bus
);
   import uart_tx_arb_pkg::*;

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(START_TIMEOUT + 1);

   state_t                r_state;
   state_t                w_next_state;
   logic [IDX_W-1:0]      r_last;
   logic [IDX_W-1:0]      r_grant_id;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic [NUM_REQ-1:0]    r_ack;
   logic                  r_tx_start;
   logic                  r_done;
   logic                  r_err;
   logic [CNT_W-1:0]      r_cnt;

   logic                  w_pick_valid;
   logic [IDX_W-1:0]      w_pick_idx;
   logic                  w_grant;
   logic                  w_timeout;
   logic                  w_frame_done;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .i_req   (bus.req),
      .i_last  (r_last),
      .o_valid (w_pick_valid),
      .o_idx   (w_pick_idx)
   );

   always_comb begin
      w_next_state = r_state;
      w_grant      = 1'b0;
      w_timeout    = 1'b0;
      w_frame_done = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!bus.tx_busy && w_pick_valid) begin
               w_grant      = 1'b1;
               w_next_state = START;
            end
         end
         START: w_next_state = WAIT_BUSY;
         WAIT_BUSY: begin
            if (bus.tx_busy) begin
               w_next_state = WAIT_DONE;
            end else if (r_cnt == CNT_W'(1)) begin
               w_timeout    = 1'b1;
               w_next_state = IDLE;
            end
         end
         WAIT_DONE: begin
            if (!bus.tx_busy) begin
               w_frame_done = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_last     <= IDX_W'(NUM_REQ - 1);
         r_grant_id <= '0;
         r_tx_data  <= '0;
         r_ack      <= '0;
         r_tx_start <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_state    <= w_next_state;
         r_ack      <= '0;
         r_tx_start <= 1'b0;
         r_done     <= w_frame_done;
         r_err      <= w_timeout;
         if (w_grant) begin
            r_ack      <= NUM_REQ'(1) << w_pick_idx;
            r_tx_start <= 1'b1;
            r_tx_data  <= bus.req_data[w_pick_idx*DATA_WIDTH +: DATA_WIDTH];
            r_grant_id <= w_pick_idx;
            r_last     <= w_pick_idx;
         end
         if (r_state == START) begin
            r_cnt <= CNT_W'(START_TIMEOUT);
         end else if (r_state == WAIT_BUSY && !bus.tx_busy) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   assign bus.ack      = r_ack;
   assign bus.tx_start = r_tx_start;
   assign bus.tx_data  = r_tx_data;
   assign bus.grant_id = r_grant_id;
   assign bus.done     = r_done;
   assign bus.err      = r_err;

`ifdef UART_TX_ARB_STATS_EN
   logic [FRAME_CNT_W-1:0] r_frame_count;
   logic [ERR_CNT_W-1:0]   r_err_count;

   // Frame count wraps naturally; error count saturates.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_count <= '0;
         r_err_count   <= '0;
      end else begin
         if (w_frame_done) r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
         if (w_timeout && r_err_count != {ERR_CNT_W{1'b1}})
            r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
   end

   assign bus.frame_count = r_frame_count;
   assign bus.err_count   = r_err_count;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner
// cases and randomized traffic against a round-robin reference model.
module tb_uart_tx_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ       (4),
      .DATA_WIDTH    (8),
      .START_TIMEOUT (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      int         exp_idx;
   } vec_t;

   vec_t       tbl[13];
   int         n_vec = 0;
   int         n_bad = 0;
   logic [3:0] rq;
   logic [7:0] bytes[4];
   int         last_m;
   int         frames_exp;
   int         errs_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      bus.req      = rq;
      bus.req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: first requesting index after 'last', wrapping around.
   function automatic int pick(input logic [3:0] r, input int last);
      for (int i = 1; i <= 4; i++) begin
         int j;
         j = (last + i) % 4;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_ack"},      32'(bus.ack),      32'd0);
      check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
      check({tag, "_tx_data"},  32'(bus.tx_data),  32'd0);
      check({tag, "_grant_id"}, 32'(bus.grant_id), 32'd0);
      check({tag, "_done"},     32'(bus.done),     32'd0);
      check({tag, "_err"},      32'(bus.err),      32'd0);
   endtask

   task automatic start_checks(input int exp);
      check("ack_onehot", 32'(bus.ack),      32'(1 << exp));
      check("grant_id",   32'(bus.grant_id), 32'(exp));
      check("tx_data",    32'(bus.tx_data),  32'(bytes[exp]));
      check("err_start",  32'(bus.err),      32'd0);
   endtask

   task automatic wait_start(input int exp);
      bit seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
         tick();
         if (k == 0) check("done_one_cycle", 32'(bus.done), 32'd0);
         if (bus.tx_start) seen = 1'b1;
      end
      check("start_seen", 32'(seen), 32'd1);
      if (seen) start_checks(exp);
   endtask

   // UART model: busy rises after the start pulse, holds len cycles, drops.
   task automatic finish_frame(input int len);
      tick();
      check("start_pulse", 32'(bus.tx_start), 32'd0);
      check("ack_pulse",   32'(bus.ack),      32'd0);
      bus.tx_busy = 1'b1;
      repeat (len) begin
         tick();
         check("no_start_busy", 32'(bus.tx_start), 32'd0);
         check("no_done_busy",  32'(bus.done),     32'd0);
      end
      bus.tx_busy = 1'b0;
      tick();
      check("done",     32'(bus.done), 32'd1);
      check("err_done", 32'(bus.err),  32'd0);
      frames_exp++;
   endtask

   task automatic run_frame(input int exp, input int len);
      wait_start(exp);
      finish_frame(len);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp;
      tbl[0]  = '{4'b1111, 0};
      tbl[1]  = '{4'b1111, 1};
      tbl[2]  = '{4'b1111, 2};
      tbl[3]  = '{4'b1111, 3};
      tbl[4]  = '{4'b1111, 0};
      tbl[5]  = '{4'b1010, 1};
      tbl[6]  = '{4'b1010, 3};
      tbl[7]  = '{4'b0101, 0};
      tbl[8]  = '{4'b0101, 2};
      tbl[9]  = '{4'b1000, 3};
      tbl[10] = '{4'b1001, 0};
      tbl[11] = '{4'b0110, 1};
      tbl[12] = '{4'b0110, 2};

      bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'h0F; bytes[3] = 8'hF0;
      rq = 4'b1111;
      bus.tx_busy = 1'b0;
      drive();
      frames_exp = 0;
      errs_exp   = 0;

      // Reset held with every request pending.
      rst = 1'b1;
      repeat (3) tick();
      check_all_zero("reset");
      rst    = 1'b0;
      last_m = 3;

      for (int i = 0; i < 13; i++) begin
         rq = tbl[i].req;
         drive();
         run_frame(tbl[i].exp_idx, 1 + (i % 3));
         last_m = tbl[i].exp_idx;
      end

      // Busy UART blocks the grant until it drops.
      bytes[2] = 8'h3C;
      rq = 4'b0100;
      drive();
      bus.tx_busy = 1'b1;
      repeat (6) begin
         tick();
         check("held_no_start", 32'(bus.tx_start), 32'd0);
         check("held_no_ack",   32'(bus.ack),      32'd0);
      end
      bus.tx_busy = 1'b0;
      tick();
      check("release_start", 32'(bus.tx_start), 32'd1);
      start_checks(2);
      finish_frame(2);
      last_m = 2;

      // Reset while the frame is in WAIT_DONE.
      rq = 4'b1111;
      drive();
      exp = pick(rq, last_m);
      wait_start(exp);
      tick();
      bus.tx_busy = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      bus.tx_busy = 1'b0;
      tick();
      check_all_zero("midreset");
      rst        = 1'b0;
      last_m     = 3;
      frames_exp = 0;
      errs_exp   = 0;
      run_frame(0, 3);
      last_m = 0;

      // Start timeout: the UART never raises busy.
      rq = 4'b1010;
      drive();
      exp = pick(rq, last_m);
      wait_start(exp);
      rq[exp] = 1'b0;
      drive();
      for (int k = 1; k <= 5; k++) begin
         tick();
         check("err_timing",      32'(bus.err),      (k == 5) ? 32'd1 : 32'd0);
         check("no_done_timeout", 32'(bus.done),     32'd0);
         check("no_start_timeout",32'(bus.tx_start), 32'd0);
      end
      errs_exp++;
      last_m = exp;
      exp = pick(rq, last_m);
      tick();
      check("err_one_cycle", 32'(bus.err),      32'd0);
      check("regrant_start", 32'(bus.tx_start), 32'd1);
      start_checks(exp);
      finish_frame(2);
      last_m = exp;

      // Randomized traffic against the reference model.
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(1) == 0) rq[last_m] = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (!rq[i] && $urandom_range(1) == 1) begin
               bytes[i] = 8'($urandom);
               rq[i]    = 1'b1;
            end
         end
         if (rq == 4'b0000) begin
            exp      = int'($urandom_range(3));
            bytes[exp] = 8'($urandom);
            rq[exp]  = 1'b1;
         end
         drive();
         exp = pick(rq, last_m);
         run_frame(exp, int'($urandom_range(1, 5)));
         last_m = exp;
      end

`ifdef UART_TX_ARB_STATS_EN
      check("frame_count", 32'(bus.frame_count), 32'(frames_exp));
      check("err_count",   32'(bus.err_count),   32'(errs_exp));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
